// File: rtl/scan_decoder.sv
// ============================================================================
//  Module   : scan_decoder
//  Brief    : Registered binary-to-one-hot decoder with enable, selectable
//             output polarity and an auto-scan mode that steps the active
//             output from index 0 up to a programmable last index, holding
//             each index for dwell+1 cycles.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module scan_decoder #(
  parameter int SEL_W      = 3,
  parameter int DWELL_W    = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  mode_i,
  input  logic [SEL_W-1:0]      sel_i,
  input  logic [SEL_W-1:0]      last_i,
  input  logic [DWELL_W-1:0]    dwell_i,
  output logic [(1<<SEL_W)-1:0] out_o,
  output logic [SEL_W-1:0]      idx_o,
  output logic                  wrap_o
);

  localparam int OUT_W = 1 << SEL_W;

  // Pattern driven when no output is active; XOR mask for active-low builds.
  localparam logic [OUT_W-1:0] C_INACTIVE = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIRECT = 2'd1;
  localparam logic [1:0] S_SCAN   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [DWELL_W-1:0] cnt_q,   cnt_d;
  logic [SEL_W-1:0]   idx_q,   idx_d;
  logic               wrap_q,  wrap_d;
  logic [OUT_W-1:0]   out_q,   out_d;
  logic               active_d;

  // Next-state logic: state follows en/mode every edge; scan stepping with
  // dwell hold and explicit compare against last for the wrap decision.
  always_comb begin
    state_d  = S_IDLE;
    cnt_d    = '0;
    idx_d    = idx_q;
    wrap_d   = 1'b0;
    active_d = 1'b0;

    if (!en_i) begin
      state_d = S_IDLE;
    end else if (!mode_i) begin
      state_d  = S_DIRECT;
      idx_d    = sel_i;
      active_d = 1'b1;
    end else begin
      state_d  = S_SCAN;
      active_d = 1'b1;
      if (state_q != S_SCAN) begin
        // Entering scan always restarts at index 0 with a fresh dwell count.
        idx_d = '0;
      end else if (cnt_q < dwell_i) begin
        cnt_d = cnt_q + DWELL_W'(1);
      end else if (idx_q >= last_i) begin
        // ">=" also catches last being lowered below the running index.
        idx_d  = '0;
        wrap_d = 1'b1;
      end else begin
        idx_d = idx_q + SEL_W'(1);
      end
    end

    out_d = active_d ? ((OUT_W'(1) << idx_d) ^ C_INACTIVE) : C_INACTIVE;
  end

  // State and output registers; reset values appear without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      out_q   <= C_INACTIVE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      out_q   <= out_d;
    end
  end

  assign out_o  = out_q;
  assign idx_o  = idx_q;
  assign wrap_o = wrap_q;

endmodule

`default_nettype wire

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parametrised, registered binary-to-one-hot decoder; generalises the 3-to-8 decoder to SEL_W inputs and 2^SEL_W outputs.
- Adds enable, selectable output polarity and an auto-scan mode: an internal counter steps the active output from 0 to a programmable last index, holding each output for a programmable dwell time.
- Drives digit-select / LED-column strobes and row-select lines in the lab designs. Sits between control logic (or a fixed select) and the display/strobe pins.

Parameters:
- SEL_W, 3, select width; output width is 2^SEL_W.
- DWELL_W, 8, width of the dwell-count input.
- ACTIVE_LOW, 0, when 1 every bit of out is inverted at the output register (inactive = 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  block enable; 0 forces all outputs inactive.
- mode  input  1  0 = direct decode of sel, 1 = auto-scan.
- sel  input  SEL_W  select value used in direct mode.
- last  input  SEL_W  highest index visited in scan mode.
- dwell  input  DWELL_W  extra hold cycles per index in scan mode; each index is held dwell+1 cycles.
- out  output  2^SEL_W  registered one-hot output, polarity set by ACTIVE_LOW.
- idx  output  SEL_W  registered index of the currently active output.
- wrap  output  1  one-cycle pulse when the scan returns from last to 0.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE; out all inactive (all 0, or all 1 when ACTIVE_LOW=1).
  - idx = 0, wrap = 0, dwell counter = 0.
  - Outputs are valid immediately on assertion, with no clock required.
- States: IDLE, DIRECT, SCAN. The state is re-evaluated on every clock edge.
  - en=0 → IDLE.
  - en=1, mode=0 → DIRECT.
  - en=1, mode=1 → SCAN.
- IDLE: out inactive; idx holds its last value; wrap = 0; dwell counter cleared.
- DIRECT:
  - out = one-hot(sel), idx = sel.
  - Latency is 1 cycle: a sel change at edge N appears on out after edge N+1.
  - wrap = 0.
- SCAN entry (from IDLE or DIRECT):
  - On the entry edge: idx = 0, out = one-hot(0), dwell counter = 0, wrap = 0.
- SCAN steady state, per edge:
  - If dwell counter < dwell: increment the counter; idx and out hold.
  - Otherwise: clear the counter and advance.
    - If idx >= last: idx = 0 and wrap = 1 for that cycle only.
    - Else: idx = idx+1.
    - out = one-hot of the new idx.
- Boundary conditions:
  - dwell=0: advance every cycle.
  - last=0: out stays on bit 0, and wrap pulses every dwell+1 cycles.
  - last = 2^SEL_W-1: full-range scan; idx wraps naturally.
  - last lowered below the current idx mid-scan: the next advance goes to 0 with a wrap pulse; no out-of-range output is ever driven.
  - dwell changed mid-hold: the new value is compared against the running counter immediately; if the counter already exceeds it, advance on the next edge.
  - mode 1→0 mid-scan: the next edge gives out = one-hot(sel), and the dwell counter is cleared.
  - en deasserted mid-scan: out inactive on the next edge. On re-enable, the scan restarts at idx 0.
  - rst mid-operation: outputs return to reset values asynchronously. After release, the first edge follows the normal state rules.
- Invariants:
  - out is exactly one-hot, or exactly all-inactive, on every cycle.
  - wrap is never high outside SCAN.
- Widths:
  - Dwell counter is DWELL_W bits and unsigned.
  - idx increment is SEL_W bits; the wrap condition is the explicit compare with last, never a carry.

Test Plan:
- Reset and polarity: SEL_W=3, ACTIVE_LOW=0, assert rst → out=8'h00, idx=0, wrap=0 with no clock. Rebuild with ACTIVE_LOW=1 → out=8'hFF.
- Direct decode: en=1, mode=0, sel stepped 0..7 one per cycle → one cycle later out = 01,02,04,...,80 and idx matches sel. Repeat with ACTIVE_LOW=1 → out = FE,FD,FB,...,7F.
- Scan with dwell: mode=1, last=3, dwell=2 → idx sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. wrap=1 only on the cycle idx returns to 0, i.e. every 12 cycles.
- Scan edge cases:
  - last=0, dwell=0 → out=01 constant and wrap=1 every cycle.
  - last=7, dwell=0 → out rotates 01..80 and wraps after 8 cycles.
- Mid-scan changes: scanning last=7, dwell=0, at idx=5 set last=2 → next idx=0 with wrap=1, then 0,1,2,0. At idx=1 switch mode=0 with sel=6 → next out=8'h40.
- Enable and reset mid-operation:
  - Drop en at idx=4 → out=00 next edge. Re-raise en → idx=0, out=01.
  - Assert rst between edges mid-scan → out=00 and idx=0 immediately.
